// File: rtl/prio_encoder_rr_pkg.sv
`default_nettype none
// ============================================================================
// encoder_pkg : shared constants for the round-robin priority encoder
// Rev 1.0
// ============================================================================
package encoder_pkg;
  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;
endpackage
`default_nettype wire

// File: rtl/prio_encoder_rr_if.sv
`default_nettype none
// ============================================================================
// prio_encoder_rr_if : request/result bundle with valid/ready back-pressure
// Rev 1.0
// ============================================================================
interface prio_encoder_rr_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic         en;
  logic [N-1:0] req;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic         out_multi;

  modport master (
    output en, req, out_ready,
    input  out_valid, out_idx, out_onehot, out_multi
  );

  modport slave (
    input  en, req, out_ready,
    output out_valid, out_idx, out_onehot, out_multi
  );
endinterface
`default_nettype wire

// File: rtl/prio_encoder_rr_scan.sv
`default_nettype none
// ============================================================================
// prio_scan : finds the first set bit scanning downward from start, wrapping
// Rev 1.0
// ============================================================================
module prio_scan #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);
  always_comb begin : scan
    int p;
    found = 1'b0;
    idx   = '0;
    p     = 0;
    for (int k = 0; k < N; k++) begin
      p = int'(start) - k;
      if (p < 0) p = p + N;
      if (!found && vec[p]) begin
        found = 1'b1;
        idx   = W'(p);
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/prio_encoder_rr.sv
`default_nettype none
// ============================================================================
// prio_encoder_rr : N-input priority encoder, fixed or round-robin, registered
// Rev 1.0
// ============================================================================
module prio_encoder_rr
  import encoder_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = MODE_FIXED
) (
  input  logic             clk,
  input  logic             rst,
  prio_encoder_rr_if.slave bus
);
  localparam int W = $clog2(N);

  logic         w_found;
  logic         w_capture;
  logic         w_multi;
  logic [W-1:0] w_start;
  logic [W-1:0] w_win;

  logic         r_valid;
  logic [W-1:0] r_idx;
  logic [N-1:0] r_onehot;
  logic         r_multi;

  prio_scan #(.N(N)) u_scan (
    .vec   (bus.req),
    .start (w_start),
    .found (w_found),
    .idx   (w_win)
  );

  // A held result blocks capture unless the consumer takes it this cycle.
  assign w_capture = bus.en & w_found & (~r_valid | bus.out_ready);
  assign w_multi   = |(bus.req & (bus.req - N'(1)));

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [W-1:0] r_ptr;

      // The granted input drops to lowest priority for the next arbitration.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ptr <= W'(N - 1);
        end else if (w_capture) begin
          r_ptr <= (w_win == '0) ? W'(N - 1) : (w_win - W'(1));
        end
      end

      assign w_start = r_ptr;
    end else begin : g_fixed
      assign w_start = W'(N - 1);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_multi  <= 1'b0;
    end else if (w_capture) begin
      r_valid  <= 1'b1;
      r_idx    <= w_win;
      r_onehot <= N'(1) << w_win;
      r_multi  <= w_multi;
    end else if (r_valid && bus.out_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign bus.out_valid  = r_valid;
  assign bus.out_idx    = r_idx;
  assign bus.out_onehot = r_onehot;
  assign bus.out_multi  = r_multi;
endmodule
`default_nettype wire

// File: tb/tb_prio_encoder_rr.sv
`default_nettype none
// ============================================================================
// tb_prio_encoder_rr : three encoder variants against a behavioural model
// Rev 1.0
// ============================================================================
module tb_prio_encoder_rr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-variant configuration: fixed N=8, round-robin N=8, round-robin N=5.
  int nn [3] = '{8, 8, 5};
  int md [3] = '{0, 1, 1};

  logic        en_v  [3];
  logic [63:0] req_v [3];
  logic        rdy_v [3];

  bit          m_valid  [3];
  int          m_idx    [3];
  logic [63:0] m_onehot [3];
  bit          m_multi  [3];
  int          m_ptr    [3];

  prio_encoder_rr_if #(.N(8)) b0 ();
  prio_encoder_rr_if #(.N(8)) b1 ();
  prio_encoder_rr_if #(.N(5)) b2 ();

  assign b0.en = en_v[0];  assign b0.req = req_v[0][7:0];  assign b0.out_ready = rdy_v[0];
  assign b1.en = en_v[1];  assign b1.req = req_v[1][7:0];  assign b1.out_ready = rdy_v[1];
  assign b2.en = en_v[2];  assign b2.req = req_v[2][4:0];  assign b2.out_ready = rdy_v[2];

  prio_encoder_rr #(.N(8), .MODE(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  prio_encoder_rr #(.N(8), .MODE(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  prio_encoder_rr #(.N(5), .MODE(1)) u2 (.clk(clk), .rst(rst), .bus(b2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int winner(int n, int mode, int ptr, logic [63:0] r);
    int start = (mode == 0) ? n - 1 : ptr;
    for (int k = 0; k < n; k++) begin
      int p = (start - k + n) % n;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_valid[d] = 0; m_idx[d] = 0; m_onehot[d] = '0; m_multi[d] = 0;
      m_ptr[d] = nn[d] - 1;
    end
  endtask

  task automatic model_step(input int d);
    logic [63:0] r;
    int w;
    r = req_v[d] & ((64'd1 << nn[d]) - 64'd1);
    if (en_v[d] && r != 0 && (!m_valid[d] || rdy_v[d])) begin
      w = winner(nn[d], md[d], m_ptr[d], r);
      m_valid[d]  = 1;
      m_idx[d]    = w;
      m_onehot[d] = 64'd1 << w;
      m_multi[d]  = ($countones(r) > 1);
      if (md[d] == 1) m_ptr[d] = (w == 0) ? nn[d] - 1 : w - 1;
    end else if (m_valid[d] && rdy_v[d]) begin
      m_valid[d] = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".v0"}, 64'(b0.out_valid),  64'(m_valid[0]));
    check({tag, ".i0"}, 64'(b0.out_idx),    64'(m_idx[0]));
    check({tag, ".o0"}, 64'(b0.out_onehot), m_onehot[0]);
    check({tag, ".m0"}, 64'(b0.out_multi),  64'(m_multi[0]));
    check({tag, ".v1"}, 64'(b1.out_valid),  64'(m_valid[1]));
    check({tag, ".i1"}, 64'(b1.out_idx),    64'(m_idx[1]));
    check({tag, ".o1"}, 64'(b1.out_onehot), m_onehot[1]);
    check({tag, ".m1"}, 64'(b1.out_multi),  64'(m_multi[1]));
    check({tag, ".v2"}, 64'(b2.out_valid),  64'(m_valid[2]));
    check({tag, ".i2"}, 64'(b2.out_idx),    64'(m_idx[2]));
    check({tag, ".o2"}, 64'(b2.out_onehot), m_onehot[2]);
    check({tag, ".m2"}, 64'(b2.out_multi),  64'(m_multi[2]));
  endtask

  task automatic set_all(input logic e, input logic [63:0] r, input logic rd);
    for (int d = 0; d < 3; d++) begin
      en_v[d] = e; req_v[d] = r; rdy_v[d] = rd;
    end
  endtask

  // Inputs are applied 1 time unit after an edge; outputs checked 1 unit after the next.
  task automatic cycle(input string tag);
    for (int d = 0; d < 3; d++) model_step(d);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    set_all(1'b0, 64'h0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst = 1'b0;
    cycle("idle");

    // One-hot walk from the top input down.
    set_all(1'b1, 64'h0, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      req_v[0] = 64'd1 << i; req_v[1] = 64'd1 << i; req_v[2] = 64'd1 << i;
      cycle("walk");
    end
    set_all(1'b1, 64'h0, 1'b1);
    cycle("drain");
    set_all(1'b0, 64'h80, 1'b1);
    repeat (2) cycle("en_off");

    set_all(1'b1, 64'h2A, 1'b1);
    cycle("multi");
    set_all(1'b1, 64'h04, 1'b1);
    cycle("single");
    set_all(1'b1, 64'h0, 1'b1);
    repeat (2) cycle("zero_req");

    // Back-pressure: result must hold while the request changes underneath.
    set_all(1'b1, 64'h10, 1'b1);
    cycle("bp_cap");
    set_all(1'b1, 64'h01, 1'b0);
    repeat (5) cycle("bp_stall");
    set_all(1'b0, 64'h01, 1'b0);
    cycle("bp_en_off");
    set_all(1'b1, 64'h01, 1'b1);
    repeat (2) cycle("bp_release");

    set_all(1'b1, 64'hFF, 1'b1);
    repeat (10) cycle("rr_all");
    set_all(1'b1, 64'h81, 1'b1);
    repeat (6) cycle("rr_81");
    set_all(1'b1, 64'h11, 1'b1);
    repeat (6) cycle("rr_11");

    // Reset while a result is stalled.
    set_all(1'b1, 64'h2C, 1'b1);
    cycle("pre_rst");
    set_all(1'b1, 64'h13, 1'b0);
    repeat (2) cycle("rst_stall");
    pulse_reset("mid_rst");
    set_all(1'b1, 64'hFF, 1'b1);
    repeat (3) cycle("post_rst");

    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 3; d++) begin
        en_v[d]  = ($urandom_range(0, 7) != 0);
        rdy_v[d] = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0:       req_v[d] = 64'h0;
          1:       req_v[d] = 64'd1 << $urandom_range(0, nn[d] - 1);
          default: req_v[d] = {32'h0, $urandom};
        endcase
      end
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
